// File: rtl/y86_pkg.sv
// Shared Y86 definitions: instruction codes, special register ids and the
// write-back queue entry payload.
package y86_pkg;

    localparam int unsigned WB_DATA_W = 64;

    localparam logic [3:0] ICODE_HALT   = 4'h0;
    localparam logic [3:0] ICODE_NOP    = 4'h1;
    localparam logic [3:0] ICODE_CMOVXX = 4'h2;
    localparam logic [3:0] ICODE_IRMOVQ = 4'h3;
    localparam logic [3:0] ICODE_RMMOVQ = 4'h4;
    localparam logic [3:0] ICODE_MRMOVQ = 4'h5;
    localparam logic [3:0] ICODE_OPQ    = 4'h6;
    localparam logic [3:0] ICODE_JXX    = 4'h7;
    localparam logic [3:0] ICODE_CALL   = 4'h8;
    localparam logic [3:0] ICODE_RET    = 4'h9;
    localparam logic [3:0] ICODE_PUSHQ  = 4'hA;
    localparam logic [3:0] ICODE_POPQ   = 4'hB;

    localparam logic [3:0] REG_RSP  = 4'd4;
    localparam logic [3:0] REG_NONE = 4'hF;

    typedef struct packed {
        logic [3:0]           addr;
        logic [WB_DATA_W-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/wb_dst_decode.sv
// Write-back destination decode: maps a W-stage bundle to its dstE/dstM
// register ids (REG_NONE = no write).
//   i_icode, i_cnd, i_ra, i_rb : W-stage bundle fields
//   o_dst_e_c, o_dst_m_c       : combinational destinations
module wb_dst_decode
    import y86_pkg::*;
(
    input  logic [3:0] i_icode,
    input  logic       i_cnd,
    input  logic [3:0] i_ra,
    input  logic [3:0] i_rb,
    output logic [3:0] o_dst_e_c,
    output logic [3:0] o_dst_m_c
);

    always_comb begin
        o_dst_e_c = REG_NONE;
        o_dst_m_c = REG_NONE;
        case (i_icode)
            ICODE_CMOVXX: o_dst_e_c = i_cnd ? i_rb : REG_NONE;
            ICODE_IRMOVQ,
            ICODE_OPQ:    o_dst_e_c = i_rb;
            ICODE_MRMOVQ: o_dst_m_c = i_ra;
            ICODE_CALL,
            ICODE_RET,
            ICODE_PUSHQ:  o_dst_e_c = REG_RSP;
            ICODE_POPQ: begin
                o_dst_e_c = REG_RSP;
                o_dst_m_c = i_ra;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/regfile_wb_scheduler.sv
// Write-port scheduler: queues 0-2 register writes per accepted W bundle,
// drains one per cycle into a single-write-port register file and forwards
// queued (not yet written) values to the two decode read ports.
//   clk, rst_n                 : clock, async active-low reset
//   wb_valid/wb_ready          : W bundle handshake
//   wb_icode..wb_valM          : W bundle contents
//   rf_we/rf_waddr/rf_wdata    : register-file write port (head of queue)
//   rd_addr_x/rf_rdata_x       : decode read address and raw RF data
//   rd_data_x                  : forwarded read data
//   q_count, busy              : queue occupancy status
module regfile_wb_scheduler
    import y86_pkg::*;
#(
    parameter int unsigned DATA_W = WB_DATA_W,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned CNT_W  = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wb_valid,
    output logic              wb_ready,
    input  logic [3:0]        wb_icode,
    input  logic              wb_cnd,
    input  logic [3:0]        wb_rA,
    input  logic [3:0]        wb_rB,
    input  logic [DATA_W-1:0] wb_valE,
    input  logic [DATA_W-1:0] wb_valM,
    output logic              rf_we,
    output logic [3:0]        rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    input  logic [3:0]        rd_addr_a,
    input  logic [3:0]        rd_addr_b,
    input  logic [DATA_W-1:0] rf_rdata_a,
    input  logic [DATA_W-1:0] rf_rdata_b,
    output logic [DATA_W-1:0] rd_data_a,
    output logic [DATA_W-1:0] rd_data_b,
    output logic [CNT_W-1:0]  q_count,
    output logic              busy
);

    localparam int unsigned PTR_W = CNT_W - 1;

    wb_entry_t        r_mem [DEPTH];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [CNT_W-1:0] r_count;

    logic [3:0]       w_dst_e;
    logic [3:0]       w_dst_m;
    logic             w_push;
    logic             w_has_e;
    logic             w_has_m;
    logic [1:0]       w_n_push;
    logic             w_pop;
    wb_entry_t        w_first;
    wb_entry_t        w_second;
    wb_entry_t        w_head;

    wb_dst_decode u_dst_decode (
        .i_icode   (wb_icode),
        .i_cnd     (wb_cnd),
        .i_ra      (wb_rA),
        .i_rb      (wb_rB),
        .o_dst_e_c (w_dst_e),
        .o_dst_m_c (w_dst_m)
    );

    // Ready depends only on registered occupancy: room for a worst-case bundle.
    assign wb_ready = (CNT_W'(DEPTH) - r_count) >= CNT_W'(2);
    assign w_push   = wb_valid & wb_ready;
    assign w_has_e  = (w_dst_e != REG_NONE);
    assign w_has_m  = (w_dst_m != REG_NONE);
    assign w_n_push = w_push ? (2'({1'b0, w_has_e}) + 2'({1'b0, w_has_m})) : 2'd0;
    assign w_pop    = (r_count != '0);

    // dstE goes first; when only dstM is present it takes the first slot.
    assign w_first  = w_has_e ? wb_entry_t'{addr: w_dst_e, data: WB_DATA_W'(wb_valE)}
                              : wb_entry_t'{addr: w_dst_m, data: WB_DATA_W'(wb_valM)};
    assign w_second = wb_entry_t'{addr: w_dst_m, data: WB_DATA_W'(wb_valM)};

    assign w_head   = r_mem[r_rptr];

    // Queue storage: data only, validity is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (w_n_push != 2'd0) r_mem[r_wptr] <= w_first;
        if (w_n_push == 2'd2) r_mem[PTR_W'(r_wptr + PTR_W'(1))] <= w_second;
    end

    // Pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            r_wptr  <= r_wptr + PTR_W'(w_n_push);
            r_rptr  <= r_rptr + PTR_W'(w_pop);
            r_count <= r_count + CNT_W'(w_n_push) - CNT_W'(w_pop);
        end
    end

    // Register-file write port presents the head combinationally.
    always_comb begin
        rf_we    = w_pop;
        rf_waddr = w_pop ? w_head.addr : REG_NONE;
        rf_wdata = w_pop ? DATA_W'(w_head.data) : '0;
    end

    // Forwarding: walk oldest to youngest so the youngest match wins.
    always_comb begin
        logic [PTR_W-1:0] idx;
        idx       = '0;
        rd_data_a = rf_rdata_a;
        rd_data_b = rf_rdata_b;
        for (int i = 0; i < int'(DEPTH); i++) begin
            idx = r_rptr + PTR_W'(i);
            if (CNT_W'(i) < r_count) begin
                if (r_mem[idx].addr == rd_addr_a) rd_data_a = DATA_W'(r_mem[idx].data);
                if (r_mem[idx].addr == rd_addr_b) rd_data_b = DATA_W'(r_mem[idx].data);
            end
        end
        if (rd_addr_a == REG_NONE) rd_data_a = '0;
        if (rd_addr_b == REG_NONE) rd_data_b = '0;
    end

    assign q_count = r_count;
    assign busy    = (r_count != '0);

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Self-checking bench: directed bundles push hand-computed register writes
// into a scoreboard; a negedge monitor pops and compares every RF write.
module tb_regfile_wb_scheduler;

    logic        clk;
    logic        rst_n;
    logic        wb_valid;
    logic        wb_ready;
    logic [3:0]  wb_icode;
    logic        wb_cnd;
    logic [3:0]  wb_rA;
    logic [3:0]  wb_rB;
    logic [63:0] wb_valE;
    logic [63:0] wb_valM;
    logic        rf_we;
    logic [3:0]  rf_waddr;
    logic [63:0] rf_wdata;
    logic [3:0]  rd_addr_a;
    logic [3:0]  rd_addr_b;
    logic [63:0] rf_rdata_a;
    logic [63:0] rf_rdata_b;
    logic [63:0] rd_data_a;
    logic [63:0] rd_data_b;
    logic [2:0]  q_count;
    logic        busy;

    typedef struct {
        logic [3:0]  a;
        logic [63:0] d;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_pass = 0;
    int   st0, st1, st2;

    regfile_wb_scheduler #(.DATA_W(64), .DEPTH(4), .CNT_W(3)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wb_valid   (wb_valid),
        .wb_ready   (wb_ready),
        .wb_icode   (wb_icode),
        .wb_cnd     (wb_cnd),
        .wb_rA      (wb_rA),
        .wb_rB      (wb_rB),
        .wb_valE    (wb_valE),
        .wb_valM    (wb_valM),
        .rf_we      (rf_we),
        .rf_waddr   (rf_waddr),
        .rf_wdata   (rf_wdata),
        .rd_addr_a  (rd_addr_a),
        .rd_addr_b  (rd_addr_b),
        .rf_rdata_a (rf_rdata_a),
        .rf_rdata_b (rf_rdata_b),
        .rd_data_a  (rd_data_a),
        .rd_data_b  (rd_data_b),
        .q_count    (q_count),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        else n_pass++;
    endtask

    // Scoreboard monitor: every RF write must match the oldest expected write.
    always @(negedge clk) begin
        if (rf_we === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_rf_write_addr", {60'd0, rf_waddr}, 64'hF);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("rf_waddr", {60'd0, rf_waddr}, {60'd0, e.a});
                chk("rf_wdata", rf_wdata, e.d);
            end
        end
    end

    // Present one bundle, wait (bounded) for acceptance, log expected writes.
    task automatic send(input logic [3:0] ic, input logic c, input logic [3:0] ra,
                        input logic [3:0] rb, input logic [63:0] ve, input logic [63:0] vm,
                        input int n, input logic [3:0] a0, input logic [63:0] d0,
                        input logic [3:0] a1, input logic [63:0] d1, output int stalls);
        wb_icode = ic; wb_cnd = c; wb_rA = ra; wb_rB = rb; wb_valE = ve; wb_valM = vm;
        wb_valid = 1'b1;
        stalls = 0;
        @(negedge clk);
        while (!wb_ready && stalls < 20) begin
            stalls++;
            @(negedge clk);
        end
        if (!wb_ready) chk("accept_timeout", 64'(wb_ready), 64'd1);
        @(posedge clk);
        if (n > 0) sb.push_back('{a: a0, d: d0});
        if (n > 1) sb.push_back('{a: a1, d: d1});
        #1;
        wb_valid = 1'b0;
        wb_icode = 4'h1;
    endtask

    task automatic wait_drain();
        int k;
        k = 0;
        while (busy && k < 50) begin
            @(posedge clk); #1;
            k++;
        end
        if (busy) chk("drain_timeout", 64'(busy), 64'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; wb_valid = 1'b0; wb_icode = 4'h1; wb_cnd = 1'b0;
        wb_rA = 4'hF; wb_rB = 4'hF; wb_valE = '0; wb_valM = '0;
        rd_addr_a = 4'hF; rd_addr_b = 4'hF; rf_rdata_a = '0; rf_rdata_b = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_q_count", 64'(q_count), 64'd0);
        chk("rst_rf_we", 64'(rf_we), 64'd0);
        chk("rst_wb_ready", 64'(wb_ready), 64'd1);
        chk("rst_busy", 64'(busy), 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // 1: irmovq rB=3 -> single write next cycle
        send(4'h3, 1'b0, 4'hF, 4'h3, 64'h55, 64'h0, 1, 4'h3, 64'h55, 4'h0, 64'h0, st0);
        chk("t1_we", 64'(rf_we), 64'd1);
        chk("t1_waddr", 64'(rf_waddr), 64'd3);
        @(posedge clk); #1;
        chk("t1_we_after", 64'(rf_we), 64'd0);
        chk("t1_waddr_idle", 64'(rf_waddr), 64'hF);
        chk("t1_wdata_idle", rf_wdata, 64'd0);

        // 2: popq rA=2 -> r4<-valE then r2<-valM
        send(4'hB, 1'b0, 4'h2, 4'hF, 64'h100, 64'hAB, 2, 4'h4, 64'h100, 4'h2, 64'hAB, st0);
        chk("t2_c1_waddr", 64'(rf_waddr), 64'd4);
        chk("t2_c1_wdata", rf_wdata, 64'h100);
        @(posedge clk); #1;
        chk("t2_c2_waddr", 64'(rf_waddr), 64'd2);
        chk("t2_c2_wdata", rf_wdata, 64'hAB);
        @(posedge clk); #1;
        chk("t2_idle_we", 64'(rf_we), 64'd0);

        // 3: three back-to-back popq, third stalls exactly one cycle
        send(4'hB, 1'b0, 4'h1, 4'hF, 64'h201, 64'h301, 2, 4'h4, 64'h201, 4'h1, 64'h301, st0);
        send(4'hB, 1'b0, 4'h2, 4'hF, 64'h202, 64'h302, 2, 4'h4, 64'h202, 4'h2, 64'h302, st1);
        send(4'hB, 1'b0, 4'h3, 4'hF, 64'h203, 64'h303, 2, 4'h4, 64'h203, 4'h3, 64'h303, st2);
        chk("t3_stall0", 64'(st0), 64'd0);
        chk("t3_stall1", 64'(st1), 64'd0);
        chk("t3_stall2", 64'(st2), 64'd1);
        wait_drain();
        chk("t3_sb_empty", 64'(sb.size()), 64'd0);

        // 4: youngest of two queued r5 writes is forwarded
        send(4'hB, 1'b0, 4'h7, 4'hF, 64'h400, 64'h401, 2, 4'h4, 64'h400, 4'h7, 64'h401, st0);
        send(4'h3, 1'b0, 4'hF, 4'h5, 64'h10, 64'h0, 1, 4'h5, 64'h10, 4'h0, 64'h0, st0);
        send(4'h3, 1'b0, 4'hF, 4'h5, 64'h20, 64'h0, 1, 4'h5, 64'h20, 4'h0, 64'h0, st0);
        rd_addr_a = 4'h5; rf_rdata_a = 64'h5;
        rd_addr_b = 4'hF; rf_rdata_b = 64'h77;
        #1;
        chk("t4_q_count", 64'(q_count), 64'd2);
        chk("t4_fwd_a", rd_data_a, 64'h20);
        chk("t4_none_b", rd_data_b, 64'd0);
        rd_addr_b = 4'h9;
        #1;
        chk("t4_nomatch_b", rd_data_b, 64'h77);
        wait_drain();
        chk("t4_rf_a", rd_data_a, 64'h5);

        // popq rA=4: both entries hit r4, valM is the younger one
        send(4'hB, 1'b0, 4'h4, 4'hF, 64'hE0, 64'hE1, 2, 4'h4, 64'hE0, 4'h4, 64'hE1, st0);
        rd_addr_a = 4'h4;
        #1;
        chk("popq_r4_fwd", rd_data_a, 64'hE1);
        rd_addr_a = 4'hF;
        wait_drain();

        // 5: zero-write bundles, then a taken cmov
        send(4'h2, 1'b0, 4'h1, 4'h6, 64'h66, 64'h0, 0, 4'h0, 64'h0, 4'h0, 64'h0, st0);
        chk("t5_cmov_stall", 64'(st0), 64'd0);
        chk("t5_cmov_count", 64'(q_count), 64'd0);
        chk("t5_cmov_we", 64'(rf_we), 64'd0);
        send(4'h1, 1'b0, 4'hF, 4'hF, 64'h0, 64'h0, 0, 4'h0, 64'h0, 4'h0, 64'h0, st0);
        chk("t5_nop_count", 64'(q_count), 64'd0);
        chk("t5_nop_we", 64'(rf_we), 64'd0);
        send(4'h2, 1'b1, 4'h1, 4'h6, 64'h66, 64'h0, 1, 4'h6, 64'h66, 4'h0, 64'h0, st0);
        send(4'h5, 1'b0, 4'h8, 4'h2, 64'h0, 64'h88, 1, 4'h8, 64'h88, 4'h0, 64'h0, st0);
        wait_drain();

        // 6: reset mid-drain discards queued writes
        send(4'hB, 1'b0, 4'h1, 4'hF, 64'h601, 64'h611, 2, 4'h4, 64'h601, 4'h1, 64'h611, st0);
        send(4'hB, 1'b0, 4'h2, 4'hF, 64'h602, 64'h612, 2, 4'h4, 64'h602, 4'h2, 64'h612, st0);
        chk("t6_pre_count", 64'(q_count), 64'd3);
        rst_n = 1'b0;
        #1;
        sb.delete();
        chk("t6_rst_count", 64'(q_count), 64'd0);
        chk("t6_rst_we", 64'(rf_we), 64'd0);
        chk("t6_rst_ready", 64'(wb_ready), 64'd1);
        chk("t6_rst_busy", 64'(busy), 64'd0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("t6_post_count", 64'(q_count), 64'd0);
        chk("t6_post_we", 64'(rf_we), 64'd0);
        chk("end_sb_empty", 64'(sb.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
